// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer stage: main register drives the output, skid catches the
// payload accepted while downstream stalls so in_ready_o can be a pure state decode.
module pipe_skid_stage #(
    parameter int                   PAYLOAD_W      = 188,
    parameter bit                   CLEAR_ON_FLUSH = 1'b1,
    parameter logic [PAYLOAD_W-1:0] FLUSH_VAL      = '0,
    parameter int                   CNT_W          = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [PAYLOAD_W-1:0] in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [PAYLOAD_W-1:0] out_data_o,
    output logic [1:0]           occupancy_o,
    output logic [CNT_W-1:0]     stall_cnt_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [PAYLOAD_W-1:0] main_q, skid_q;
    logic [CNT_W-1:0]     stall_q;
    logic                 accept, take;
    logic                 ld_main_in, ld_main_skid, ld_main_flush, ld_skid;

    // Handshake outputs decode the state register only, no input-to-output paths.
    assign in_ready_o  = (state_q != FULL);
    assign out_valid_o = (state_q != EMPTY);
    assign occupancy_o = state_q;
    assign out_data_o  = main_q;
    assign stall_cnt_o = stall_q;

    assign accept = in_valid_i & in_ready_o;
    assign take   = out_valid_o & out_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        ld_main_in    = 1'b0;
        ld_main_skid  = 1'b0;
        ld_main_flush = 1'b0;
        ld_skid       = 1'b0;
        if (flush_i) begin
            state_d       = EMPTY;
            ld_main_flush = CLEAR_ON_FLUSH;
        end else begin
            case (state_q)
                EMPTY: if (accept) begin
                    ld_main_in = 1'b1;
                    state_d    = ONE;
                end
                ONE: begin
                    if (accept && take) begin
                        ld_main_in = 1'b1;
                    end else if (accept) begin
                        ld_skid = 1'b1;
                        state_d = FULL;
                    end else if (take) begin
                        state_d = EMPTY;
                    end
                end
                FULL: if (take) begin
                    ld_main_skid = 1'b1;
                    state_d      = ONE;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (ld_main_flush)     main_q <= FLUSH_VAL;
            else if (ld_main_in)   main_q <= in_data_i;
            else if (ld_main_skid) main_q <= skid_q;
            if (ld_skid) skid_q <= in_data_i;
        end
    end

    // Counts upstream stalls independent of flush; sticks at all-ones.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            stall_q <= '0;
        else if (in_valid_i && !in_ready_o && (stall_q != {CNT_W{1'b1}}))
            stall_q <= stall_q + 1'b1;
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: queue of accepted payloads models the
// two entries; a CNT_W=2 twin shares the stimulus to exercise counter saturation.
module tb_pipe_skid_stage;
    localparam int W = 188;

    logic         clk = 1'b0;
    logic         rst, flush, in_valid, out_ready;
    logic [W-1:0] in_data;
    logic         in_ready, out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   occ;
    logic [15:0]  stall;
    logic         s_in_ready, s_out_valid;
    logic [W-1:0] s_out_data;
    logic [1:0]   s_occ;
    logic [1:0]   s_stall;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] q[$];
    int exp_stall, exp_sat;

    always #5 clk = ~clk;

    pipe_skid_stage dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .in_data_i(in_data), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_data_o(out_data), .occupancy_o(occ),
        .stall_cnt_o(stall)
    );

    pipe_skid_stage #(.CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(s_in_ready), .in_data_i(in_data), .out_valid_o(s_out_valid),
        .out_ready_i(out_ready), .out_data_o(s_out_data), .occupancy_o(s_occ),
        .stall_cnt_o(s_stall)
    );

    function automatic logic [W-1:0] rnd_payload();
        logic [191:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return r[W-1:0];
    endfunction

    // One clock: score the take, push the accept, advance, then check state.
    task automatic cycle();
        logic acc, tk;
        acc = in_valid && (q.size() < 2);
        tk  = out_ready && (q.size() > 0);
        if (tk) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== q[0]) begin
                errors++;
                $display("FAIL take_data got v=%0b %h want %h", out_valid, out_data, q[0]);
            end
            void'(q.pop_front());
        end
        if (in_valid && q.size() >= 2 - (tk ? 1 : 0) && !acc) begin
            if (exp_stall < 65535) exp_stall++;
            if (exp_sat < 3) exp_sat++;
        end
        if (flush) q.delete();
        else if (acc) q.push_back(in_data);
        @(posedge clk); #1;
        checks++;
        if (occ !== 2'(q.size()) || in_ready !== (q.size() < 2) ||
            out_valid !== (q.size() > 0)) begin
            errors++;
            $display("FAIL state got occ=%0d rdy=%0b vld=%0b want occ=%0d", occ, in_ready,
                     out_valid, q.size());
        end
        checks++;
        if (stall !== 16'(exp_stall) || s_stall !== 2'(exp_sat)) begin
            errors++;
            $display("FAIL stall_cnt got %0d/%0d want %0d/%0d", stall, s_stall, exp_stall, exp_sat);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        #1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete(); exp_stall = 0; exp_sat = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        #2;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || occ !== 2'd0 || out_data !== '0 ||
            stall !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%0b vld=%0b occ=%0d data=%h cnt=%0d",
                     in_ready, out_valid, occ, out_data, stall);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete(); exp_stall = 0; exp_sat = 0;
        // first edge after release must accept
        in_valid = 1'b1; in_data = W'(16'h5a5a);
        cycle();
        checks++;
        if (out_data !== W'(16'h5a5a)) begin
            errors++;
            $display("FAIL first_accept got %h want 5a5a", out_data);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        cycle();
    endtask

    task automatic test_streaming();
        apply_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1; in_data = W'(i);
            cycle();
            checks++;
            if (out_data !== W'(i) || occ !== 2'd1) begin
                errors++;
                $display("FAIL stream_latency got %h occ=%0d want %0d occ=1", out_data, occ, i);
            end
        end
        in_valid = 1'b0;
        cycle();
        checks++;
        if (stall !== 16'd0) begin
            errors++;
            $display("FAIL stream_stall got %0d want 0", stall);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = W'(32'hA); cycle();
        in_data = W'(32'hB); cycle();
        checks++;
        if (occ !== 2'd2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full got occ=%0d rdy=%0b want 2/0", occ, in_ready);
        end
        in_data = W'(32'hC);
        repeat (3) cycle();
        checks++;
        if (stall !== 16'd3) begin
            errors++;
            $display("FAIL bp_stall got %0d want 3", stall);
        end
        out_ready = 1'b1;
        cycle();
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();
        checks++;
        if (q.size() != 0 || out_valid !== 1'b0 || out_data !== W'(32'hC)) begin
            errors++;
            $display("FAIL bp_drain got vld=%0b data=%h want 0/c", out_valid, out_data);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = W'(32'h11); cycle();
        in_data = W'(32'h22); cycle();
        in_data = W'(32'h33); flush = 1'b1; cycle();
        flush = 1'b0;
        checks++;
        if (occ !== 2'd0 || out_valid !== 1'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL flush_full got occ=%0d vld=%0b data=%h want 0/0/0", occ, out_valid, out_data);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) cycle();
        // flush with a simultaneous take: the taken payload is still scored
        in_valid = 1'b1; in_data = W'(32'h44); cycle();
        in_data = W'(32'h55); flush = 1'b1; cycle();
        flush = 1'b0; in_valid = 1'b0;
        cycle();
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL flush_take got vld=%0b data=%h want 0/0", out_valid, out_data);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = W'(32'h77); cycle();
        in_data = W'(32'h88); cycle();
        in_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || occ !== 2'd0 || out_data !== '0 ||
            stall !== 16'd0) begin
            errors++;
            $display("FAIL async_reset got rdy=%0b vld=%0b occ=%0d data=%h", in_ready, out_valid,
                     occ, out_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete(); exp_stall = 0; exp_sat = 0;
        out_ready = 1'b1;
        cycle();
    endtask

    task automatic test_saturation();
        apply_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = W'(32'h1); cycle();
        in_data = W'(32'h2); cycle();
        repeat (5) cycle();
        checks++;
        if (s_stall !== 2'd3 || stall !== 16'd5) begin
            errors++;
            $display("FAIL saturation got %0d/%0d want 3/5", s_stall, stall);
        end
        out_ready = 1'b1; in_valid = 1'b0;
        repeat (3) cycle();
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            in_data   = rnd_payload();
            cycle();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) cycle();
    endtask

    initial begin
        exp_stall = 0; exp_sat = 0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
